wam_mol: RTL and testbench
==========================

# wam_mol

Mole generator for the Whac-A-Mole game, directly downstream of the difficulty-parameter decoder. It consumes the per-difficulty mole lifetime (`age`) and spawn threshold (`rto`), and:
- spawns moles pseudo-randomly into holes;
- ages each live mole once per game step;
- resolves debounced whack pulses into hit, bad-hit and miss events.

Its registered mole map drives the hole LEDs, and its event pulses feed the score counter.

## Interface
Parameters:
- `HOLES`, 16: number of holes; power of two, 4..16.
- `STEP_DIV`, 24: `clk_19` cycles per game step, ≥2.

Ports:
- `clk_19`  in  1  game clock.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  game running. Low clears the board.
- `age`  in  4  mole lifetime in steps, 0..15. Sampled at spawn.
- `rto`  in  8  spawn threshold. Spawn attempt succeeds when rnd < `rto`.
- `hit`  in  `HOLES`  one-cycle whack pulses, one bit per hole. Already debounced.
- `mol`  out  `HOLES`  live-mole map, registered.
- `hit_ok`  out  1  pulse: at least one whack landed on a live mole.
- `hit_bad`  out  1  pulse: at least one whack landed on an empty hole.
- `miss`  out  1  pulse: at least one mole expired unhit.
- `step`  out  1  pulse on each game-step cycle.

## Operation
- **LFSR:** 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1.
  - Advances every `clk_19` cycle regardless of `en`.
  - rnd = lfsr[7:0]; idx = lfsr[8 +: log2(HOLES)].
- **Step counter:** 0..STEP_DIV-1, counting only while `en`=1.
  - `step` asserts in the cycle it equals STEP_DIV-1; the counter then wraps to 0.
- **Per-hole state:** live bit `mol[i]` and 4-bit lifetime `life[i]`.
- **Hits:** evaluated every cycle against the current `mol`.
  - hit[i] & mol[i]: clear `mol[i]` and `life[i]`; counts toward `hit_ok`.
  - hit[i] & ~mol[i]: counts toward `hit_bad`.
  - Both pulses may assert in the same cycle.
- **Aging, on step cycles:** for every live, unhit hole:
  - life==0: clear `mol[i]`; counts toward `miss`.
  - otherwise: life <= life-1.
  - A mole spawned with `age`=A is therefore visible for A+1 steps.
- **Spawn, on step cycles:** if rnd < `rto`, ~mol[idx] and ~hit[idx], then set mol[idx]=1 and life[idx]=`age`.
  - The spawned mole is not aged in its spawn step.
  - At most one spawn per step.
  - Occupied target: no spawn, no retry.
  - `rto`=0: never spawns. `rto`=255: spawns on all rnd except 255.
- **Simultaneous events on one hole:** hit beats expiry.
  - A hole that is live, at life==0, and hit on a step cycle yields `hit_ok`, not `miss`.
- **`en`=0:**
  - `mol`, all `life` and the step counter clear synchronously.
  - No events assert, even when `hit` pulses arrive.
  - Operation resumes on the first cycle `en`=1; the first `step` follows STEP_DIV cycles later.

## Timing
- All outputs are registered.
- `mol` and the event pulses update in the cycle after the causing `hit` or step edge. Latency is 1 `clk_19` cycle.
- `hit_ok`, `hit_bad`, `miss` and `step` are single-cycle pulses.
- **Async reset (`clr_n`=0):**
  - `mol`=0, `life`=0, step counter=0, all pulses 0, LFSR=16'hACE1.
  - Assertion mid-step takes effect immediately.
  - Release is synchronous to `clk_19` through the codebase's standard deassertion flop pair.
- `age` and `rto` are sampled only at the spawn cycle. Difficulty changes never alter moles already live.

## Structure
- Shared package `wam_pkg`:
  - LFSR_SEED = 16'hACE1;
  - LFSR_TAPS mask;
  - AGE_W = 4;
  - RTO_W = 8.
- Sub-module `wam_lfsr`: clk, async reset, 16-bit state output, free-running. Reused later by other random-placement blocks.
- Per-hole logic is a generate loop in `wam_mol`. Event pulses are OR-reductions of the per-hole flags, registered.

## Test plan
- **Reset and idle.** Sequence: hold `clr_n`=0, then release with `en`=0 for 100 cycles. Required: `mol`=0, no pulses, LFSR sequence from 16'hACE1 matches the model.
- **Spawn and expiry.** Stimulus: `en`=1, `rto`=255, `age`=2, force an empty board. Required: a mole appears in the step where rnd<255 at hole idx and is lit for exactly 3 steps; `miss` pulses once at its expiry step.
- **Hit.** Whack a live mole mid-life. Required:
  - next cycle: that `mol` bit is 0 and `hit_ok`=1 for one cycle;
  - no `miss` for that hole afterwards.
- **Bad hit and collision.**
  - hit[5] with mol[5]=0: `hit_bad`=1 for one cycle.
  - hit on a live life==0 mole in a step cycle: `hit_ok`=1, `miss`=0.
  - hit[idx] in a spawn cycle: no spawn.
- **Thresholds.**
  - `rto`=0 for 1000 steps: `mol` stays 0.
  - `rto`=87: spawn count matches the LFSR reference model exactly.
  - change `age` 14→7 with moles live: existing lifetimes are unchanged.
- **Disable mid-game.** With 4 moles live, drop `en` for 1 cycle. Required: `mol`=0, no `miss`, the step counter restarts, and the first `step` comes STEP_DIV cycles after `en` returns.

Source files
------------

// File: rtl/wam_pkg.sv
// wam_pkg: shared constants, event bundle and LFSR step for the whac-a-mole blocks
package wam_pkg;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int AGE_W = 4;
  localparam int RTO_W = 8;
  typedef struct packed {
    logic hit_ok;
    logic hit_bad;
    logic miss;
    logic step;
  } wam_evt_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/wam_lfsr.sv
// wam_lfsr: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1
module wam_lfsr
  import wam_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);
  logic [15:0] state_q, state_d;
  always_comb state_d = lfsr_next(state_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= LFSR_SEED;
    else state_q <= state_d;
  assign state = state_q;
endmodule

// File: rtl/wam_mol.sv
// wam_mol: spawns, ages and resolves whacks on the whac-a-mole board
module wam_mol
  import wam_pkg::*;
#(
  parameter int HOLES    = 16,
  parameter int STEP_DIV = 24
) (
  input  logic              clk_19,
  input  logic              clr_n,
  input  logic              en,
  input  logic [AGE_W-1:0]  age,
  input  logic [RTO_W-1:0]  rto,
  input  logic [HOLES-1:0]  hit,
  output logic [HOLES-1:0]  mol,
  output logic              hit_ok,
  output logic              hit_bad,
  output logic              miss,
  output logic              step
);
  localparam int IW = $clog2(HOLES);
  localparam int CW = $clog2(STEP_DIV);
  logic [1:0] sync_q;
  logic rst_n;
  logic [15:0] lfsr;
  logic lfsr_unused;
  logic [RTO_W-1:0] rnd;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HOLES-1:0] mol_q, mol_d, ok_v, bad_v, exp_v, spn_v;
  logic [HOLES-1:0][AGE_W-1:0] life_q, life_d;
  logic step_now, spawn_ok;
  wam_evt_t evt_q, evt_d;
  always_ff @(posedge clk_19 or negedge clr_n)
    if (!clr_n) sync_q <= 2'b00;
    else sync_q <= {sync_q[0], 1'b1};
  assign rst_n = sync_q[1];
  wam_lfsr u_lfsr (.clk(clk_19), .rst_n(rst_n), .state(lfsr));
  assign rnd = lfsr[RTO_W-1:0];
  assign idx = lfsr[8 +: IW];
  assign lfsr_unused = ^lfsr[15:8+IW];
  always_comb begin
    step_now = en && (cnt_q == CW'(STEP_DIV - 1));
    cnt_d    = (!en || step_now) ? '0 : cnt_q + CW'(1);
    spawn_ok = step_now && (rnd < rto);
    evt_d    = '{hit_ok: |ok_v, hit_bad: |bad_v, miss: |exp_v, step: step_now};
  end
  // a hit on a hole always wins over its expiry and blocks a spawn into it
  for (genvar i = 0; i < HOLES; i++) begin : g_hole
    assign ok_v[i]   = en & hit[i] & mol_q[i];
    assign bad_v[i]  = en & hit[i] & ~mol_q[i];
    assign exp_v[i]  = step_now & mol_q[i] & ~hit[i] & (life_q[i] == '0);
    assign spn_v[i]  = spawn_ok & (idx == IW'(i)) & ~mol_q[i] & ~hit[i];
    assign mol_d[i]  = en & (spn_v[i] | (mol_q[i] & ~hit[i] & ~exp_v[i]));
    assign life_d[i] = (!en || ok_v[i]) ? '0 :
                       spn_v[i] ? age :
                       (step_now & mol_q[i] & |life_q[i]) ? life_q[i] - AGE_W'(1) : life_q[i];
  end
  always_ff @(posedge clk_19 or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      mol_q  <= '0;
      life_q <= '0;
      evt_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mol_q  <= mol_d;
      life_q <= life_d;
      evt_q  <= evt_d;
    end
  assign mol     = mol_q;
  assign hit_ok  = evt_q.hit_ok;
  assign hit_bad = evt_q.hit_bad;
  assign miss    = evt_q.miss;
  assign step    = evt_q.step;
endmodule

// File: tb/tb_wam_mol.sv
// tb_wam_mol: scoreboard bench for wam_mol with a cycle model and directed checks
module tb_wam_mol;
  localparam int H  = 16;
  localparam int SD = 24;
  logic clk_19 = 1'b0;
  logic clr_n = 1'b0;
  logic en = 1'b0;
  logic [3:0] age = '0;
  logic [7:0] rto = '0;
  logic [H-1:0] hit = '0;
  logic [H-1:0] mol;
  logic hit_ok, hit_bad, miss, step;
  wam_mol #(.HOLES(H), .STEP_DIV(SD)) dut (
    .clk_19(clk_19), .clr_n(clr_n), .en(en), .age(age), .rto(rto), .hit(hit),
    .mol(mol), .hit_ok(hit_ok), .hit_bad(hit_bad), .miss(miss), .step(step)
  );
  always #5 clk_19 = ~clk_19;
  typedef struct packed {
    logic [H-1:0] mol;
    logic ok, bad, ms, st;
  } exp_t;
  exp_t sq[$];
  string dn[$];
  logic [31:0] dg[$], dw[$];
  int vec = 0, err = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [1:0] m_sync = 2'b00;
  int m_cnt = 0, m_spawns = 0;
  logic [H-1:0] m_mol = '0;
  int m_life[H];
  always @(negedge clk_19) begin
    exp_t e;
    string n;
    logic [31:0] g, w;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      vec++;
      if ({mol, hit_ok, hit_bad, miss, step} !== e) begin
        err++;
        $display("FAIL scoreboard t=%0t got mol=%h ok=%b bad=%b miss=%b step=%b want mol=%h ok=%b bad=%b miss=%b step=%b",
                 $time, mol, hit_ok, hit_bad, miss, step, e.mol, e.ok, e.bad, e.ms, e.st);
      end
    end
    while (dn.size() > 0) begin
      n = dn.pop_front();
      g = dg.pop_front();
      w = dw.pop_front();
      vec++;
      if (g !== w) begin
        err++;
        $display("FAIL %s got %0d want %0d", n, g, w);
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] w);
    dn.push_back(n);
    dg.push_back(g);
    dw.push_back(w);
  endtask
  task automatic tick();
    exp_t e;
    logic [H-1:0] nm;
    int nl[H];
    logic st;
    int ix;
    e = '0;
    nm = m_mol;
    nl = m_life;
    if (!clr_n) begin
      m_sync = 2'b00;
      m_lfsr = 16'hACE1;
      m_cnt = 0;
      nm = '0;
      for (int i = 0; i < H; i++) nl[i] = 0;
    end else if (!m_sync[1]) begin
      m_sync = {m_sync[0], 1'b1};
    end else begin
      ix = int'(m_lfsr[11:8]);
      st = en && (m_cnt == SD - 1);
      if (!en) begin
        nm = '0;
        m_cnt = 0;
        for (int i = 0; i < H; i++) nl[i] = 0;
      end else begin
        m_cnt = st ? 0 : m_cnt + 1;
        for (int i = 0; i < H; i++) begin
          if (hit[i]) begin
            if (m_mol[i]) begin e.ok = 1'b1; nm[i] = 1'b0; nl[i] = 0; end
            else e.bad = 1'b1;
          end else if (st && m_mol[i]) begin
            if (m_life[i] == 0) begin nm[i] = 1'b0; e.ms = 1'b1; end
            else nl[i] = m_life[i] - 1;
          end
        end
        if (st && m_lfsr[7:0] < rto && !m_mol[ix] && !hit[ix]) begin
          nm[ix] = 1'b1;
          nl[ix] = int'(age);
          m_spawns++;
        end
        e.st = st;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    m_mol = nm;
    m_life = nl;
    e.mol = nm;
    sq.push_back(e);
    @(posedge clk_19);
    @(negedge clk_19);
    #1;
  endtask
  function automatic int first1(input logic [H-1:0] v);
    for (int i = 0; i < H; i++) if (v[i]) return i;
    return 0;
  endfunction
  function automatic int zero_life_live();
    int c = 0;
    for (int i = 0; i < H; i++) if (m_mol[i] && m_life[i] == 0) c++;
    return c;
  endfunction
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, h, lit, ms, ds, s0;
    logic [H-1:0] prev, any;
    for (int i = 0; i < H; i++) m_life[i] = 0;
    @(negedge clk_19);
    #1;
    repeat (5) tick();
    chk("reset_mol", 32'(mol), 0);
    chk("reset_pulses", 32'({hit_ok, hit_bad, miss, step}), 0);
    clr_n = 1'b1;
    repeat (100) tick();
    chk("idle_mol", 32'(mol), 0);
    // spawn and expiry
    en = 1'b1; rto = 8'd255; age = 4'd2;
    n = 0;
    while (mol == '0 && n < 200) begin tick(); n++; end
    chk("spawn_seen", 32'(mol != '0), 1);
    chk("spawn_on_step", 32'(step), 1);
    h = first1(mol);
    lit = 0; ms = 0; n = 0;
    while (mol[h] && n < 200) begin lit++; ms += int'(miss); tick(); n++; end
    chk("lit_cycles", lit, 3 * SD);
    chk("miss_before_expiry", ms, 0);
    chk("expiry_miss", 32'(miss), 1);
    // hit mid-life
    n = 0;
    h = -1;
    while (h < 0 && n < 500) begin
      for (int i = 0; i < H; i++) if (m_mol[i] && m_life[i] >= 1 && m_cnt < SD - 2) h = i;
      if (h < 0) begin tick(); n++; end
    end
    chk("hit_target_found", 32'(h >= 0), 1);
    if (h >= 0) begin
      hit[h] = 1'b1; tick(); hit = '0;
      chk("hit_clears", 32'(mol[h]), 0);
      chk("hit_ok_pulse", 32'(hit_ok), 1);
      chk("hit_not_bad", 32'(hit_bad), 0);
      tick();
      chk("hit_ok_single", 32'(hit_ok), 0);
    end
    // bad hit on hole 5
    rto = 8'd0;
    n = 0;
    while (mol[5] && n < 2000) begin tick(); n++; end
    hit[5] = 1'b1; tick(); hit = '0;
    chk("bad_hit", 32'(hit_bad), 1);
    chk("bad_hit_no_ok", 32'(hit_ok), 0);
    tick();
    chk("bad_hit_single", 32'(hit_bad), 0);
    // hit beats expiry
    rto = 8'd255; age = 4'd0;
    n = 0;
    while (!(m_cnt == SD - 1 && zero_life_live() == 1) && n < 5000) begin tick(); n++; end
    chk("collide_found", 32'(n < 5000), 1);
    h = -1;
    for (int i = 0; i < H; i++) if (m_mol[i] && m_life[i] == 0) h = i;
    if (h >= 0) begin
      hit[h] = 1'b1; tick(); hit = '0;
      chk("expiry_hit_ok", 32'(hit_ok), 1);
      chk("expiry_hit_no_miss", 32'(miss), 0);
      chk("expiry_hit_mol", 32'(mol[h]), 0);
    end
    // hit on the spawn target blocks the spawn
    n = 0;
    while (!(m_cnt == SD - 1 && m_lfsr[7:0] < rto && !m_mol[m_lfsr[11:8]]) && n < 5000) begin tick(); n++; end
    h = int'(m_lfsr[11:8]);
    hit[h] = 1'b1; tick(); hit = '0;
    chk("no_spawn_on_hit", 32'(mol[h]), 0);
    chk("spawn_hit_bad", 32'(hit_bad), 1);
    // rto=0 for 1000 steps
    en = 1'b0; tick();
    chk("clear_board", 32'(mol), 0);
    en = 1'b1; rto = 8'd0; any = '0;
    repeat (1000 * SD) begin tick(); any |= mol; end
    chk("rto0_never", 32'(any), 0);
    // rto=87 spawn count
    en = 1'b0; tick(); en = 1'b1; rto = 8'd87; age = 4'd3;
    s0 = m_spawns; ds = 0; prev = mol;
    repeat (300 * SD) begin tick(); ds += $countones(mol & ~prev); prev = mol; end
    chk("rto87_spawns", ds, m_spawns - s0);
    chk("rto87_nonzero", 32'(ds > 0), 1);
    // age change leaves live moles alone
    en = 1'b0; tick(); en = 1'b1; rto = 8'd255; age = 4'd14;
    n = 0;
    while (mol == '0 && n < 200) begin tick(); n++; end
    h = first1(mol);
    age = 4'd7; rto = 8'd0;
    lit = 0; n = 0;
    while (mol[h] && n < 1000) begin lit++; tick(); n++; end
    chk("age_kept", lit, 15 * SD);
    chk("age_kept_miss", 32'(miss), 1);
    // disable mid-game
    rto = 8'd255; age = 4'd15;
    n = 0;
    while ($countones(mol) < 4 && n < 2000) begin tick(); n++; end
    chk("four_live", 32'($countones(mol) >= 4), 1);
    en = 1'b0; hit = '1; tick(); hit = '0;
    chk("dis_mol", 32'(mol), 0);
    chk("dis_events", 32'({hit_ok, hit_bad, miss, step}), 0);
    en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!step && n < 100);
    chk("first_step_delay", n, SD);
    // async reset mid-cycle
    n = 0;
    while (mol == '0 && n < 200) begin tick(); n++; end
    #2;
    clr_n = 1'b0;
    #1;
    chk("async_mol", 32'(mol), 0);
    chk("async_pulses", 32'({hit_ok, hit_bad, miss, step}), 0);
    repeat (3) tick();
    clr_n = 1'b1;
    repeat (3 * SD) tick();
    repeat (2) @(negedge clk_19);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
